// File: rtl/axi_dma_2d_issuer.sv
// 2D DMA job issuer: turns one (row length x repetitions) job into one backend
// burst request per row, then reports completion once every row has finished.
module axi_dma_2d_issuer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned RepWidth       = 32,
  parameter int unsigned JobIdWidth     = 8,
  parameter int unsigned MaxOutstanding = 16,
  localparam int unsigned ReqWidth      = IdWidth + 3 * AddrWidth + 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [AddrWidth-1:0]  job_src_i,
  input  logic [AddrWidth-1:0]  job_dst_i,
  input  logic [AddrWidth-1:0]  job_num_bytes_i,
  input  logic [AddrWidth-1:0]  job_src_stride_i,
  input  logic [AddrWidth-1:0]  job_dst_stride_i,
  input  logic [RepWidth-1:0]   job_num_reps_i,
  input  logic [IdWidth-1:0]    job_axi_id_i,
  input  logic [3:0]            job_cache_src_i,
  input  logic [3:0]            job_cache_dst_i,
  input  logic                  job_decouple_rw_i,
  input  logic                  job_deburst_i,
  output logic [JobIdWidth-1:0] job_id_o,
  output logic [ReqWidth-1:0]   burst_req_o,
  output logic                  burst_valid_o,
  input  logic                  burst_ready_i,
  input  logic                  trans_complete_i,
  output logic                  job_done_o,
  output logic [JobIdWidth-1:0] job_done_id_o,
  output logic                  busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  // Handshake rule for both job and burst ports: a transfer happens on a rising
  // clock edge where valid and ready are both high; valid never waits on ready
  // and, once raised, valid and its payload hold until that edge.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  // Field order of burst_req_o, MSB first.
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [AddrWidth-1:0] num_bytes;
    logic [3:0]           cache_src;
    logic [3:0]           cache_dst;
    logic [1:0]           burst_src;
    logic [1:0]           burst_dst;
    logic                 decouple_rw;
    logic                 deburst;
    logic                 serialize;
  } burst_req_t;

  state_e state_q, state_d;

  logic [IdWidth-1:0]    id_q;
  logic [AddrWidth-1:0]  src_q, dst_q, num_bytes_q, src_stride_q, dst_stride_q;
  logic [RepWidth-1:0]   rem_q;
  logic [3:0]            cache_src_q, cache_dst_q;
  logic                  decouple_q, deburst_q;
  logic [JobIdWidth-1:0] job_id_q, done_id_q;
  logic [CntWidth-1:0]   out_q, out_d;

  logic       job_hs, burst_hs, comp, zero_job;
  burst_req_t req;

  assign job_hs   = job_valid_i && job_ready_o;
  assign burst_hs = burst_valid_o && burst_ready_i;
  assign comp     = trans_complete_i && (out_q != '0);
  assign zero_job = (job_num_reps_i == '0) || (job_num_bytes_i == '0);

  always_comb begin
    out_d = out_q;
    if (burst_hs && !comp) out_d = out_q + CntWidth'(1);
    else if (!burst_hs && comp) out_d = out_q - CntWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // DRAIN looks at the next count so DONE follows the final completion directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_hs) state_d = zero_job ? DONE : ISSUE;
      ISSUE:   if (burst_hs && (rem_q == RepWidth'(1))) state_d = DRAIN;
      DRAIN:   if (out_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    job_ready_o   = (state_q == IDLE);
    burst_valid_o = (state_q == ISSUE) && (out_q < MaxCnt);
    job_done_o    = (state_q == DONE);
    busy_o        = (state_q != IDLE) || (out_q != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q         <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      num_bytes_q  <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      rem_q        <= '0;
      cache_src_q  <= '0;
      cache_dst_q  <= '0;
      decouple_q   <= 1'b0;
      deburst_q    <= 1'b0;
      job_id_q     <= '0;
      done_id_q    <= '0;
      out_q        <= '0;
    end else begin
      if (job_hs) begin
        id_q         <= job_axi_id_i;
        src_q        <= job_src_i;
        dst_q        <= job_dst_i;
        num_bytes_q  <= job_num_bytes_i;
        src_stride_q <= job_src_stride_i;
        dst_stride_q <= job_dst_stride_i;
        rem_q        <= job_num_reps_i;
        cache_src_q  <= job_cache_src_i;
        cache_dst_q  <= job_cache_dst_i;
        decouple_q   <= job_decouple_rw_i;
        deburst_q    <= job_deburst_i;
        done_id_q    <= job_id_q;
        job_id_q     <= job_id_q + JobIdWidth'(1);
      end
      if (burst_hs) begin
        src_q <= src_q + src_stride_q;
        dst_q <= dst_q + dst_stride_q;
        rem_q <= rem_q - RepWidth'(1);
      end
      out_q <= out_d;
    end
  end

  // The request is zeroed outside ISSUE so idle/reset shows an all-zero bus.
  always_comb begin
    req = '0;
    if (state_q == ISSUE) begin
      req.id          = id_q;
      req.src         = src_q;
      req.dst         = dst_q;
      req.num_bytes   = num_bytes_q;
      req.cache_src   = cache_src_q;
      req.cache_dst   = cache_dst_q;
      req.burst_src   = 2'b01;
      req.burst_dst   = 2'b01;
      req.decouple_rw = decouple_q;
      req.deburst     = deburst_q;
      req.serialize   = 1'b1;
    end
  end

  assign burst_req_o   = req;
  assign job_id_o      = job_id_q;
  assign job_done_id_o = done_id_q;

  stray_complete_chk : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(trans_complete_i && (out_q == '0)))
    else $warning("trans_complete_i with no outstanding rows is ignored");

endmodule
